// File: rtl/alu_uart_master.sv
// ---------------------------------------------------------------------------
// alu_uart_master
//
// Initiator for the ALU-over-UART protocol. On an accepted start it latches
// the operands and sends the three-byte frame [A] [B] [OP] through a
// byte-level UART interface (tx_start/tx_data/tx_done). It then waits for a
// single result byte (rx_data/rx_done), bounded by a timeout. The result can
// optionally be compared with an expected value.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   start              : transaction request, only honoured in IDLE
//   op_a, op_b         : operands A and B
//   op_code            : operation, zero-extended to 8 bits on the wire
//   expected, check_en : expected result and compare enable
//   tx_start, tx_data  : one-cycle send pulse and the byte being sent
//   tx_done            : transmitter finished the current byte
//   rx_data, rx_done   : received byte and its one-cycle strobe
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse at the end of each transaction
//   result             : last received result byte
//   timeout, mismatch  : sticky status of the last transaction
// ---------------------------------------------------------------------------
module alu_uart_master #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int OP_WIDTH       = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          op_a,
    input  logic [7:0]          op_b,
    input  logic [OP_WIDTH-1:0] op_code,
    input  logic [7:0]          expected,
    input  logic                check_en,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_done,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    output logic                busy,
    output logic                done,
    output logic [7:0]          result,
    output logic                timeout,
    output logic                mismatch
);

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SEND_A    = 4'd1,
        S_WAIT_A    = 4'd2,
        S_SEND_B    = 4'd3,
        S_WAIT_B    = 4'd4,
        S_SEND_OP   = 4'd5,
        S_WAIT_OP   = 4'd6,
        S_WAIT_RESP = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [7:0]       op_q;
    logic [7:0]       exp_q;
    logic             chk_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       result_q;
    logic             timeout_q;
    logic             mismatch_q;
    logic             cnt_term_s;

    assign cnt_term_s = (cnt_q == CNT_LAST);

    // Next-state decode; rx_done takes priority over the terminal count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start)   state_d = S_SEND_A;    else state_d = S_IDLE;
            S_SEND_A:    state_d = S_WAIT_A;
            S_WAIT_A:    if (tx_done) state_d = S_SEND_B;    else state_d = S_WAIT_A;
            S_SEND_B:    state_d = S_WAIT_B;
            S_WAIT_B:    if (tx_done) state_d = S_SEND_OP;   else state_d = S_WAIT_B;
            S_SEND_OP:   state_d = S_WAIT_OP;
            S_WAIT_OP:   if (tx_done) state_d = S_WAIT_RESP; else state_d = S_WAIT_OP;
            S_WAIT_RESP: begin
                if (rx_done || cnt_term_s) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State register, latched operands, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            op_q       <= 8'd0;
            exp_q      <= 8'd0;
            chk_q      <= 1'b0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 8'd0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != S_IDLE);
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        op_q       <= 8'(op_code);
                        exp_q      <= expected;
                        chk_q      <= check_en;
                        timeout_q  <= 1'b0;
                        mismatch_q <= 1'b0;
                    end
                end
                S_SEND_A: begin
                    tx_data_q  <= a_q;
                    tx_start_q <= 1'b1;
                end
                S_SEND_B: begin
                    tx_data_q  <= b_q;
                    tx_start_q <= 1'b1;
                end
                S_SEND_OP: begin
                    tx_data_q  <= op_q;
                    tx_start_q <= 1'b1;
                end
                S_WAIT_OP: begin
                    // Clearing here means the counter can never wrap in WAIT_RESP.
                    if (tx_done) begin
                        cnt_q <= '0;
                    end
                end
                S_WAIT_RESP: begin
                    if (rx_done) begin
                        result_q   <= rx_data;
                        mismatch_q <= chk_q & (rx_data != exp_q);
                    end else if (cnt_term_s) begin
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign timeout  = timeout_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_alu_uart_master.sv
// ---------------------------------------------------------------------------
// tb_alu_uart_master
//
// Drives transactions into alu_uart_master while acting as the UART and the
// remote responder. Expected frames and results come from a transaction-level
// model and are queued; independent monitors pop and compare whenever the
// DUT emits a byte (tx_start) or finishes a transaction (done).
// ---------------------------------------------------------------------------
module tb_alu_uart_master;

    localparam int T   = 100;  // timeout in cycles
    localparam int OPW = 6;
    localparam int TXD = 10;   // UART byte time seen by the bench

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [7:0]     op_a;
    logic [7:0]     op_b;
    logic [OPW-1:0] op_code;
    logic [7:0]     expected;
    logic           check_en;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic [7:0]     rx_data;
    logic           rx_done;
    logic           busy;
    logic           done;
    logic [7:0]     result;
    logic           timeout;
    logic           mismatch;

    always #5 clk = ~clk;

    alu_uart_master #(.TIMEOUT_CYCLES(T), .OP_WIDTH(OPW)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .op_code(op_code), .expected(expected), .check_en(check_en),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .rx_data(rx_data), .rx_done(rx_done), .busy(busy), .done(done),
        .result(result), .timeout(timeout), .mismatch(mismatch)
    );

    typedef struct {
        logic [7:0] result;
        logic       tmo;
        logic       mm;
        int         lat;   // posedges from the OP tx_done sample to done visible
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] byte_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         resp_base = 0;
    int         done_count = 0;
    logic [7:0] last_tx = 8'd0;
    logic [7:0] model_result = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Byte monitor: every tx_start must carry the next expected frame byte.
    initial begin
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (byte_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got tx_data 0x%0h, required no byte", tx_data);
                end else begin
                    eb = byte_q.pop_front();
                    check("tx_byte", tx_data, eb);
                    last_tx = eb;
                end
            end
            if (tx_done === 1'b1) check("tx_data_stable", tx_data, last_tx);
        end
    end

    // Result monitor: each done pulse closes the oldest outstanding transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: got done=1, required 0");
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.result);
                    check("timeout", timeout, e.tmo);
                    check("mismatch", mismatch, e.mm);
                    check("done_latency", cyc - resp_base, e.lat);
                    check("busy_at_done", busy, 1'b0);
                end
            end
        end
    end

    // Runs one transaction. k = responder delay in cycles after the OP byte
    // completes (0 = never answers). special: 1 = start pulse while waiting
    // for A, 2 = stray rx_done while waiting for B, 3 = reset while waiting for B.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [OPW-1:0] op,
                           input logic [7:0] ex, input logic ce, input int k,
                           input logic [7:0] rb, input int special);
        exp_t e;
        int   dc0;
        bit   ok;
        dc0 = done_count;
        if (k >= 1 && k <= T) begin
            e.result = rb;
            e.tmo    = 1'b0;
            e.mm     = ce && (rb != ex);
            e.lat    = k + 1;
        end else begin
            e.result = model_result;
            e.tmo    = 1'b1;
            e.mm     = 1'b0;
            e.lat    = T + 1;
        end
        @(negedge clk);
        op_a = a; op_b = b; op_code = op; expected = ex; check_en = ce; start = 1'b1;
        byte_q.push_back(a);
        byte_q.push_back(b);
        byte_q.push_back({{(8-OPW){1'b0}}, op});
        if (special != 3) begin
            sb_q.push_back(e);
            model_result = e.result;
        end
        @(negedge clk);
        start = 1'b0;
        op_a = 8'($urandom); op_b = 8'($urandom); op_code = OPW'($urandom);
        expected = 8'($urandom); check_en = 1'($urandom);
        check("timeout_cleared", timeout, 1'b0);
        check("mismatch_cleared", mismatch, 1'b0);
        @(negedge clk);
        check("tx_start_latency", tx_start, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ok = 1'b0;
            for (int w = 0; w < 20; w++) begin
                if (tx_start === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_start_wait: got no tx_start for byte %0d, required one", i);
            end
            for (int d = 0; d < TXD; d++) begin
                if (i == 0 && special == 1 && d == 2) begin
                    check("busy_in_wait", busy, 1'b1);
                    start = 1'b1;
                    op_a  = 8'hFF;
                end else begin
                    start = 1'b0;
                end
                if (i == 1 && special == 2 && d == 4) begin
                    rx_done = 1'b1;
                    rx_data = 8'($urandom);
                end else begin
                    rx_done = 1'b0;
                end
                if (i == 1 && special == 3 && d == 5) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    check("rst_busy", busy, 1'b0);
                    check("rst_tx_start", tx_start, 1'b0);
                    check("rst_tx_data", tx_data, 8'd0);
                    check("rst_result", result, 8'd0);
                    check("rst_done", done, 1'b0);
                    check("rst_timeout", timeout, 1'b0);
                    byte_q.delete();
                    model_result = 8'd0;
                    last_tx = 8'd0;
                    repeat (30) @(negedge clk);
                    check("rst_no_done", done_count, dc0);
                    return;
                end
                @(negedge clk);
            end
            start   = 1'b0;
            rx_done = 1'b0;
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        resp_base = cyc;
        if (k > 0) begin
            repeat (k - 1) @(negedge clk);
            rx_done = 1'b1;
            rx_data = rb;
            @(negedge clk);
            rx_done = 1'b0;
            rx_data = 8'($urandom);
        end
        ok = 1'b0;
        for (int w = 0; w < T + 20; w++) begin
            if (done_count != dc0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_wait: got no done pulse, required one");
        end
        repeat (2) @(negedge clk);
    endtask

    // Unsolicited rx_done and tx_done while idle must have no effect.
    task automatic idle_noise();
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = 8'($urandom);
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         r;
        int         k;
        logic [7:0] ex;
        logic [7:0] rb;
        reset = 1'b1; start = 1'b0; op_a = 8'd0; op_b = 8'd0; op_code = '0;
        expected = 8'd0; check_en = 1'b0; tx_done = 1'b0; rx_done = 1'b0; rx_data = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_tx_start", tx_start, 1'b0);
        check("reset_tx_data", tx_data, 8'd0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 8'd0);
        check("reset_timeout", timeout, 1'b0);
        check("reset_mismatch", mismatch, 1'b0);
        reset = 1'b0;
        idle_noise();

        run_txn(8'h05, 8'h03, 6'h20, 8'h08, 1'b1, 10, 8'h08, 0);   // nominal
        run_txn(8'h05, 8'h03, 6'h20, 8'h08, 1'b1, 10, 8'h09, 0);   // mismatch
        run_txn(8'h05, 8'h03, 6'h20, 8'h08, 1'b0, 10, 8'h09, 0);   // compare disabled
        run_txn(8'h11, 8'h22, 6'h01, 8'h33, 1'b1, 0,  8'h00, 0);   // timeout
        run_txn(8'h44, 8'h55, 6'h02, 8'h00, 1'b1, T,  8'h42, 0);   // rx on terminal count
        run_txn(8'h66, 8'h77, 6'h03, 8'h10, 1'b1, T + 1, 8'h10, 0); // one cycle late
        run_txn(8'h12, 8'h34, 6'h3F, 8'h46, 1'b1, 1,  8'h46, 2);   // stray rx in WAIT_B
        run_txn(8'hA5, 8'h5A, 6'h15, 8'hFF, 1'b1, 5,  8'hFF, 1);   // start while busy
        run_txn(8'hC3, 8'h3C, 6'h0A, 8'h01, 1'b1, 5,  8'h01, 3);   // reset in WAIT_B
        run_txn(8'h01, 8'h02, 6'h04, 8'h03, 1'b1, 7,  8'h03, 0);   // fresh frame after reset

        for (int n = 0; n < 25; n++) begin
            r  = $urandom_range(0, 9);
            ex = 8'($urandom);
            if (r == 0)      k = 0;
            else if (r == 1) k = T;
            else if (r == 2) k = T + 1;
            else             k = $urandom_range(1, 30);
            rb = ($urandom_range(0, 1) == 1) ? ex : 8'($urandom);
            run_txn(8'($urandom), 8'($urandom), OPW'($urandom), ex, 1'($urandom), k, rb,
                    $urandom_range(0, 2));
            if (n % 5 == 0) idle_noise();
        end

        repeat (10) @(negedge clk);
        check("bytes_drained", byte_q.size(), 0);
        check("results_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
